alu_rr_scheduler: RTL and testbench

//  Shares one 8-bit alu instance between N_REQ requesters. Round-robin arbitration, valid/ready handshake per requester.

---
 rtl/alu_rr_scheduler_pkg.sv | 26 ++
 rtl/alu_rr_scheduler_if.sv | 29 ++
 rtl/alu_rr_scheduler_alu.sv | 36 +++
 rtl/alu_rr_scheduler.sv | 107 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types and widths for the round-robin ALU scheduler slice.
// ALU select codes, scheduler states and datapath widths.
package alu_rr_scheduler_pkg;

  localparam int unsigned RES_W  = 16;
  localparam int unsigned OPND_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [SEL_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    SHR = 3'd2,
    SHL = 3'd3,
    AND = 3'd4,
    OR  = 3'd5,
    XOR = 3'd6,
    NOT = 3'd7
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the client blocks and the ALU scheduler.
// master = client side, slave = scheduler side.
interface alu_rr_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  import alu_rr_scheduler_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [SEL_W*N_REQ-1:0]  req_op;
  logic [OPND_W*N_REQ-1:0] req_a;
  logic [OPND_W*N_REQ-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [RES_W-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// Combinational 8-bit ALU with a 16-bit result; operands are zero-extended.
// Output is forced to zero when not enabled.
module alu_rr_scheduler_alu
  import alu_rr_scheduler_pkg::*;
(
  input  logic [OPND_W-1:0] in0,
  input  logic [OPND_W-1:0] in1,
  input  alu_sel_t          sel,
  input  logic              en,
  output logic [RES_W-1:0]  out
);

  logic [RES_W-1:0] a16;
  logic [RES_W-1:0] b16;
  logic [RES_W-1:0] res;

  assign a16 = {{(RES_W-OPND_W){1'b0}}, in0};
  assign b16 = {{(RES_W-OPND_W){1'b0}}, in1};

  always_comb begin
    res = '0;
    unique case (sel)
      ADD: res = a16 + b16;
      SUB: res = a16 - b16;
      SHR: res = a16 >> 1;
      SHL: res = a16 << 1;
      AND: res = a16 & b16;
      OR:  res = a16 | b16;
      XOR: res = a16 ^ b16;
      NOT: res = ~a16;
    endcase
  end

  assign out = en ? res : '0;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration.
// One operation in flight at a time: IDLE (arbitrate) -> EXEC -> RESP.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_scheduler_if.slave bus,
  output logic              busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_last;
  alu_sel_t          op_q;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [RES_W-1:0]  rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              grant_any;
  logic [ID_W-1:0]   winner;
  logic [N_REQ-1:0]  ready;
  logic [RES_W-1:0]  alu_out;

  // First valid requester strictly after rr_last, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(rr_last) + k) % int'(N_REQ);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == IDLE && grant_any) begin
      ready[winner] = 1'b1;
    end
  end

  alu_rr_scheduler_alu u_alu (
    .in0 (a_q),
    .in1 (b_q),
    .sel (op_q),
    .en  (1'b1),
    .out (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= ID_W'(N_REQ - 1);
      op_q        <= ADD;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            op_q    <= alu_sel_t'(bus.req_op[SEL_W*int'(winner) +: SEL_W]);
            a_q     <= bus.req_a[OPND_W*int'(winner) +: OPND_W];
            b_q     <= bus.req_b[OPND_W*int'(winner) +: OPND_W];
            id_q    <= winner;
            rr_last <= winner;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          // Back to IDLE only; a request pending now is arbitrated next cycle.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model (round-robin search, arithmetic results, latency).
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  alu_rr_scheduler_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  alu_rr_scheduler #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_have;
  int          m_last;
  int          m_acc;
  int          m_id;
  logic [15:0] m_res;
  int          cyc = 0;
  int          grants[$];
  int          acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a / 2;
      3: r = a * 2;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 32'hFFFF - a;
    endcase
    return r[15:0];
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v);
    if (m_have) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // Check outputs mid-cycle, advance the model, return just after the next rising edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    bit exp_rv;
    @(negedge clk);
    if (rst) begin
      m_have = 1'b0;
      m_last = N - 1;
    end else begin
      g = exp_grant(bus.req_valid);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rv = m_have && (cyc >= m_acc + 2);
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("busy", 32'(busy), 32'(m_have));
      if (exp_rv) begin
        check("rsp_data", 32'(bus.rsp_data), 32'(m_res));
        check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      end
      if (exp_rv && bus.rsp_ready) begin
        m_have = 1'b0;
      end else if (g >= 0) begin
        m_have = 1'b1;
        m_acc  = cyc;
        m_id   = g;
        m_res  = ref_alu(int'(bus.req_op[3*g +: 3]), int'(bus.req_a[8*g +: 8]),
                         int'(bus.req_b[8*g +: 8]));
        m_last = g;
        grants.push_back(g);
        acc_cyc.push_back(cyc);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic set_req(input int i, input alu_sel_t op, input logic [7:0] a,
                         input logic [7:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_op[3*i +: 3]   = op;
    bus.req_a[8*i +: 8]    = a;
    bus.req_b[8*i +: 8]    = b;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_one(input int id, input alu_sel_t op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp, input string tag);
    idle_inputs();
    bus.rsp_ready = 1'b1;
    set_req(id, op, a, b);
    cycle();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_early"}, 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = '0;
    cycle();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    cycle();
  endtask

  function automatic int count_grants(input int id);
    int n = 0;
    foreach (grants[i]) if (grants[i] == id) n++;
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n3;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    idle_inputs();
    m_have = 1'b0;
    m_last = N - 1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset values
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // 1: ADD with carry into bit 8
    run_one(0, ADD, 8'hFF, 8'h01, 16'h0100, "t1_add");

    // 2: all requesters valid, grant order and spacing
    do_reset();
    grants.delete();
    acc_cyc.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, alu_sel_t'(i), 8'(8'h10 + i), 8'(8'h03 * i));
    repeat (15) cycle();
    idle_inputs();
    repeat (3) cycle();
    check("t2_ngrants", 32'(grants.size() >= 5), 32'd1);
    if (grants.size() >= 5) begin
      check("t2_g0", 32'(grants[0]), 32'd0);
      check("t2_g1", 32'(grants[1]), 32'd1);
      check("t2_g2", 32'(grants[2]), 32'd2);
      check("t2_g3", 32'(grants[3]), 32'd3);
      check("t2_g4", 32'(grants[4]), 32'd0);
      check("t2_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'd3);
    end

    // 3: SUB wraps, response held while rsp_ready low
    idle_inputs();
    bus.rsp_ready = 1'b0;
    set_req(2, SUB, 8'd3, 8'd5);
    cycle();
    bus.req_valid = '0;
    cycle();
    bus.req_valid = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_data", 32'(bus.rsp_data), 32'h0000_FFFE);
      check("t3_id", 32'(bus.rsp_id), 32'd2);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_ready", 32'(bus.req_ready), 32'd0);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    cycle();
    idle_inputs();
    repeat (4) cycle();

    // 4: NOT / SHL / SHR
    run_one(1, NOT, 8'h0F, 8'h00, 16'hFFF0, "t4_not");
    run_one(1, SHL, 8'h80, 8'h00, 16'h0100, "t4_shl");
    run_one(1, SHR, 8'h81, 8'h00, 16'h0040, "t4_shr");

    // 5: reset during EXEC drops the op and restores priority
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(3, ADD, 8'h01, 8'h01);
    cycle();
    bus.req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    set_req(0, OR, 8'h50, 8'h05);
    set_req(3, AND, 8'hF0, 8'h3C);
    #1;
    check("t5_prio", 32'(bus.req_ready), 32'd1);
    cycle();
    idle_inputs();
    repeat (3) cycle();

    // 6: short pulse from req 3 while req 1 is busy
    bus.rsp_ready = 1'b1;
    set_req(1, XOR, 8'hA5, 8'h0F);
    cycle();
    n3 = count_grants(3);
    bus.req_valid = '0;
    set_req(3, ADD, 8'h22, 8'h11);
    cycle();
    idle_inputs();
    repeat (4) cycle();
    check("t6_no_grant3", 32'(count_grants(3)), 32'(n3));
    check("t6_idle", 32'(busy), 32'd0);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
      bus.req_op    = 12'($urandom);
      bus.req_a     = 32'($urandom);
      bus.req_b     = 32'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
